ibuf_pp_writer: RTL
===================

IBUF_PP_WRITER -- requirements
Module: ibuf_pp_writer

Interface
REQ-001 SHALL have parameter WD, default 8, pixel width in bits.
REQ-002 SHALL have parameter W, default 256, pixels per line.
REQ-003 SHALL have parameter H, default 256, lines per frame.
REQ-004 SHALL have parameter WA, default $clog2(W*H*2), buffer address width covering two banks.
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port s_valid  input  1  upstream pixel valid.
REQ-008 SHALL have port s_ready  output  1  pixel accepted when s_valid&s_ready.
REQ-009 SHALL have port s_data  input  WD  pixel value.
REQ-010 SHALL have port s_sof  input  1  marks first pixel of a frame.
REQ-011 SHALL have port mem_cs  output  1  buffer chip select.
REQ-012 SHALL have port mem_we  output  1  buffer write enable.
REQ-013 SHALL have port mem_addr  output  WA  buffer address.
REQ-014 SHALL have port mem_din  output  WD  buffer write data.
REQ-015 SHALL have port bank_full  output  2  per-bank "frame ready for consumer" flags.
REQ-016 SHALL have port bank_rel  input  2  consumer one-cycle release pulse per bank.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse when a bank completes.
REQ-018 SHALL have port done_bank  output  1  bank index valid with frame_done.
REQ-019 SHALL have port sof_err  output  1  one-cycle pulse on unexpected s_sof.

Function
REQ-020 SHALL implement states IDLE (no free bank), WAIT_SOF (bank free, discarding until s_sof), FILL (writing frame).
REQ-021 SHALL drive s_ready=1 in WAIT_SOF and FILL, 0 in IDLE.
REQ-022 SHALL, in WAIT_SOF, accept and drop beats with s_sof=0; a beat with s_sof=1 is written at index 0 and moves to FILL.
REQ-023 SHALL address mem as wr_bank*W*H + pix_idx, pix_idx = row*W + col, 0..W*H-1, incrementing per written beat.
REQ-024 SHALL register mem_cs, mem_we, mem_addr, mem_din: accepted beat at cycle N appears on mem port at cycle N+1 with cs=we=1; cs=we=0 otherwise.
REQ-025 SHALL, in FILL, on accepted beat with s_sof=1 and pix_idx!=0, pulse sof_err, write that pixel at index 0, restart count.
REQ-026 SHALL, on accepting pix_idx=W*H-1, in next cycle: set bank_full[wr_bank], pulse frame_done with done_bank=wr_bank, toggle wr_bank.
REQ-027 SHALL then enter WAIT_SOF if bank_full of the new wr_bank is clear (including release in same cycle), else IDLE.
REQ-028 SHALL clear bank_full[b] the cycle after bank_rel[b]; bank_rel on a clear flag SHALL be ignored; both bits may release simultaneously.
REQ-029 SHALL leave IDLE for WAIT_SOF the cycle after bank_full[wr_bank] clears.
REQ-030 SHALL never write to a bank whose bank_full is set.

Reset
REQ-031 SHALL on rstn low asynchronously set state=WAIT_SOF, wr_bank=0, pix_idx=0, bank_full=2'b00, mem_cs=mem_we=0, mem_addr=0, mem_din=0, frame_done=0, done_bank=0, sof_err=0; partial frame discarded.

Structure
REQ-032 SHALL place state encoding and bank-index constants in shared package ibuf_pkg.
REQ-033 SHALL be a single module with no sub-modules; drives mem_single-style port directly.

Verification (W=H=4)
REQ-034 SHALL test: 16 beats, first s_sof=1, data 0..15 -> mem writes addr 0..15 one cycle later, frame_done with done_bank=0, bank_full=01.
REQ-035 SHALL test: second frame -> addr 16..31, bank_full=11, s_ready=0; bank_rel=01 -> s_ready=1 two cycles later, third frame writes addr 0..15.
REQ-036 SHALL test: 3 beats without sof then sof frame -> no writes for first 3, frame at addr 0.
REQ-037 SHALL test: s_sof at pix_idx=5 -> sof_err pulse, that pixel at addr 0, frame completes after 16 more beats.
REQ-038 SHALL test: rstn low at pix_idx=7 -> all outputs reset values, bank_full=00, next sof writes addr 0.
REQ-039 SHALL test: random s_valid gaps -> write sequence identical to gapless case.

Source files
------------

// File: rtl/ibuf_pkg.sv
// -----------------------------------------------------------------------------
// ibuf_pkg
// Shared definitions for the ping-pong input frame buffer writer.
//   ibuf_state_e : writer FSM state encoding
//   NUM_BANKS    : number of frame banks (two, ping-pong)
//   BANK0/BANK1  : bank index constants
//   bank_mask()  : one-hot bank flag mask for a bank index
// -----------------------------------------------------------------------------
package ibuf_pkg;

    // IDLE     : no free bank, upstream stalled
    // WAIT_SOF : a bank is free, beats are dropped until a start-of-frame
    // FILL     : a frame is being written into the current bank
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_SOF = 2'b01,
        ST_FILL     = 2'b10
    } ibuf_state_e;

    localparam int   NUM_BANKS = 2;
    localparam logic BANK0     = 1'b0;
    localparam logic BANK1     = 1'b1;

    // One-hot mask selecting the bank_full bit that belongs to a bank index.
    function automatic logic [NUM_BANKS-1:0] bank_mask(input logic bank);
        logic [NUM_BANKS-1:0] mask;
        if (bank == BANK1) begin
            mask = 2'b10;
        end else begin
            mask = 2'b01;
        end
        return mask;
    endfunction

endpackage

// File: rtl/ibuf_pp_writer.sv
// -----------------------------------------------------------------------------
// ibuf_pp_writer
// Writes an incoming pixel stream into a two-bank (ping-pong) frame buffer.
// A frame is only started on a beat flagged s_sof, and only while the bank
// about to be written is not still held by the consumer. A completed bank is
// flagged in bank_full until the consumer releases it with bank_rel.
//
// Parameters
//   WD : pixel width in bits
//   W  : pixels per line
//   H  : lines per frame
//   WA : buffer address width (covers both banks)
//
// Ports
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   s_valid    in   upstream pixel valid
//   s_ready    out  writer can accept a beat (WAIT_SOF or FILL)
//   s_data     in   pixel value
//   s_sof      in   first pixel of a frame
//   mem_cs     out  buffer chip select (registered)
//   mem_we     out  buffer write enable (registered)
//   mem_addr   out  buffer address = bank*W*H + pixel index (registered)
//   mem_din    out  buffer write data (registered)
//   bank_full  out  per-bank "frame ready for consumer" flags
//   bank_rel   in   per-bank one-cycle release pulse from the consumer
//   frame_done out  one-cycle pulse when a bank completes
//   done_bank  out  bank index that completed, valid with frame_done
//   sof_err    out  one-cycle pulse when s_sof arrives mid-frame
// -----------------------------------------------------------------------------
module ibuf_pp_writer
    import ibuf_pkg::*;
#(
    parameter int WD = 8,
    parameter int W  = 256,
    parameter int H  = 256,
    parameter int WA = $clog2(W*H*2)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WD-1:0]        s_data,
    input  logic                 s_sof,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [WA-1:0]        mem_addr,
    output logic [WD-1:0]        mem_din,
    output logic [NUM_BANKS-1:0] bank_full,
    input  logic [NUM_BANKS-1:0] bank_rel,
    output logic                 frame_done,
    output logic                 done_bank,
    output logic                 sof_err
);

    localparam int             NPIX      = W * H;
    localparam int             IW        = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [IW-1:0]  LAST_IDX  = IW'(NPIX - 1);
    localparam logic [WA-1:0]  BANK_SIZE = WA'(NPIX);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    ibuf_state_e          state_r;
    logic                 wr_bank_r;
    logic [IW-1:0]        pix_idx_r;
    logic [NUM_BANKS-1:0] bank_full_r;
    logic                 s_ready_r;
    logic                 mem_cs_r;
    logic                 mem_we_r;
    logic [WA-1:0]        mem_addr_r;
    logic [WD-1:0]        mem_din_r;
    logic                 frame_done_r;
    logic                 done_bank_r;
    logic                 sof_err_r;

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    logic                 accept_s;
    logic                 write_s;
    logic                 sof_err_s;
    logic                 last_s;
    logic [IW-1:0]        wr_idx_s;
    logic [NUM_BANKS-1:0] set_mask_s;
    logic [NUM_BANKS-1:0] bank_full_nxt_s;
    logic                 other_bank_s;
    ibuf_state_e          post_frame_s;
    ibuf_state_e          state_nxt_s;
    logic [IW-1:0]        pix_idx_nxt_s;
    logic                 wr_bank_nxt_s;
    logic [WA-1:0]        wr_addr_s;

    assign accept_s     = s_valid & s_ready_r;
    assign other_bank_s = ~wr_bank_r;

    // Decide whether the accepted beat is written, and at which pixel index.
    always_comb begin
        write_s   = 1'b0;
        sof_err_s = 1'b0;
        wr_idx_s  = pix_idx_r;
        case (state_r)
            ST_WAIT_SOF: begin
                // Beats before the first s_sof are accepted but dropped.
                if (accept_s && s_sof) begin
                    write_s  = 1'b1;
                    wr_idx_s = '0;
                end else begin
                    write_s  = 1'b0;
                    wr_idx_s = pix_idx_r;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    write_s = 1'b1;
                    if (s_sof) begin
                        // A new frame start resynchronises to index 0; it is
                        // only an error if it cut a frame short.
                        wr_idx_s  = '0;
                        sof_err_s = (pix_idx_r != '0);
                    end else begin
                        wr_idx_s  = pix_idx_r;
                        sof_err_s = 1'b0;
                    end
                end else begin
                    write_s  = 1'b0;
                    wr_idx_s = pix_idx_r;
                end
            end
            default: begin
                write_s   = 1'b0;
                sof_err_s = 1'b0;
                wr_idx_s  = pix_idx_r;
            end
        endcase
    end

    // Frame completion, bank flag update and write address.
    always_comb begin
        last_s = write_s && (wr_idx_s == LAST_IDX);
        if (last_s) begin
            set_mask_s = bank_mask(wr_bank_r);
        end else begin
            set_mask_s = '0;
        end
        // Release of a clear flag is harmless: clearing a zero bit is a no-op.
        // The bank being filled is never full, so set and release never collide.
        bank_full_nxt_s = (bank_full_r & ~bank_rel) | set_mask_s;

        if (wr_bank_r == BANK1) begin
            wr_addr_s = BANK_SIZE + WA'(wr_idx_s);
        end else begin
            wr_addr_s = WA'(wr_idx_s);
        end

        if (write_s) begin
            if (last_s) begin
                pix_idx_nxt_s = '0;
            end else begin
                pix_idx_nxt_s = wr_idx_s + IW'(1);
            end
        end else begin
            pix_idx_nxt_s = pix_idx_r;
        end

        if (last_s) begin
            wr_bank_nxt_s = other_bank_s;
        end else begin
            wr_bank_nxt_s = wr_bank_r;
        end

        // After a frame the next bank may be free already, including a
        // release arriving in the completion cycle itself.
        if (bank_full_nxt_s[other_bank_s]) begin
            post_frame_s = ST_IDLE;
        end else begin
            post_frame_s = ST_WAIT_SOF;
        end
    end

    // FSM next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                // Uses the registered flag, so exit happens the cycle after it clears.
                if (bank_full_r[wr_bank_r]) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (last_s) begin
                    state_nxt_s = post_frame_s;
                end else if (write_s) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_WAIT_SOF;
                end
            end
            ST_FILL: begin
                if (last_s) begin
                    state_nxt_s = post_frame_s;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            default: begin
                state_nxt_s = ST_WAIT_SOF;
            end
        endcase
    end

    // FSM state, frame bookkeeping and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_WAIT_SOF;
            wr_bank_r    <= BANK0;
            pix_idx_r    <= '0;
            bank_full_r  <= 2'b00;
            s_ready_r    <= 1'b1;
            mem_cs_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_din_r    <= '0;
            frame_done_r <= 1'b0;
            done_bank_r  <= BANK0;
            sof_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            wr_bank_r    <= wr_bank_nxt_s;
            pix_idx_r    <= pix_idx_nxt_s;
            bank_full_r  <= bank_full_nxt_s;
            s_ready_r    <= (state_nxt_s != ST_IDLE);
            mem_cs_r     <= write_s;
            mem_we_r     <= write_s;
            frame_done_r <= last_s;
            sof_err_r    <= sof_err_s;
            if (write_s) begin
                mem_addr_r <= wr_addr_s;
                mem_din_r  <= s_data;
            end else begin
                mem_addr_r <= mem_addr_r;
                mem_din_r  <= mem_din_r;
            end
            if (last_s) begin
                done_bank_r <= wr_bank_r;
            end else begin
                done_bank_r <= done_bank_r;
            end
        end
    end

    assign s_ready    = s_ready_r;
    assign mem_cs     = mem_cs_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_din    = mem_din_r;
    assign bank_full  = bank_full_r;
    assign frame_done = frame_done_r;
    assign done_bank  = done_bank_r;
    assign sof_err    = sof_err_r;

endmodule
